// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl
//   Issue controller that sits between a request port and an iterative
//   multiplier. It accepts one MUL/MULH/MULHSU/MULHU request, launches the
//   multiplier with a one-cycle pulse, waits for completion (or abandons
//   after TIMEOUT wait cycles), and presents the selected 32-bit half of the
//   product on a valid/ready writeback port. All outputs are registered.
//
// Ports
//   clk, rst          : clock (rising edge) and asynchronous active-low reset
//   req_valid/ready   : request handshake; ready only while idle
//   req_funct3        : 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 1xx illegal
//   req_rs1/rs2/rd    : operands and destination tag
//   flush             : discard the op currently in flight
//   mul_rs1/rs2       : operands to the multiplier, held for the whole op
//   mul_rs1/2_signed  : operand signedness to the multiplier
//   mul_start         : one-cycle launch pulse
//   mul_result/valid  : product and one-cycle completion pulse
//   mul_busy          : multiplier cannot accept a launch yet
//   wb_valid/ready    : writeback handshake
//   wb_data/rd/err    : selected result half, tag, illegal-op or timeout flag
//
// state  | meaning
// IDLE   | ready for a request
// LAUNCH | op latched, waiting for the multiplier to be free to pulse start
// WAIT   | start issued, waiting for mul_valid or timeout
// RESP   | writeback presented, waiting for wb_ready

module mul_issue_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic [31:0] mul_rs1,
  output logic [31:0] mul_rs2,
  output logic        mul_rs1_signed,
  output logic        mul_rs2_signed,
  output logic        mul_start,
  input  logic [63:0] mul_result,
  input  logic        mul_valid,
  input  logic        mul_busy,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Wait timer is a down-counter: loaded on the launch, terminal at zero,
  // so the op sits in WAIT for exactly TIMEOUT cycles before giving up.
  localparam logic [7:0] WAIT_LOAD = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nx;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_cnt_nx;
  logic        drop;
  logic        drop_nx;
  logic        hi_sel;
  logic        hi_sel_nx;

  logic        req_ready_nx;
  logic        mul_start_nx;
  logic        wb_valid_nx;
  logic        wb_err_nx;
  logic [31:0] wb_data_nx;
  logic [4:0]  wb_rd_nx;
  logic [31:0] mul_rs1_nx;
  logic [31:0] mul_rs2_nx;
  logic        mul_rs1_signed_nx;
  logic        mul_rs2_signed_nx;

  logic        accept;
  logic        illegal;
  logic        launch_go;
  logic        wait_tc;
  logic        wait_end;

  // A flush coincident with the handshake drops the new request outright.
  assign accept    = req_valid && req_ready && !flush;
  assign illegal   = req_funct3[2];
  assign launch_go = !flush && !mul_busy;
  assign wait_tc   = (wait_cnt == 8'd0);
  assign wait_end  = mul_valid || wait_tc;

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      wait_cnt       <= 8'd0;
      drop           <= 1'b0;
      hi_sel         <= 1'b0;
      req_ready      <= 1'b0;
      mul_start      <= 1'b0;
      wb_valid       <= 1'b0;
      wb_err         <= 1'b0;
      wb_data        <= 32'd0;
      wb_rd          <= 5'd0;
      mul_rs1        <= 32'd0;
      mul_rs2        <= 32'd0;
      mul_rs1_signed <= 1'b0;
      mul_rs2_signed <= 1'b0;
    end else begin
      state          <= state_nx;
      wait_cnt       <= wait_cnt_nx;
      drop           <= drop_nx;
      hi_sel         <= hi_sel_nx;
      req_ready      <= req_ready_nx;
      mul_start      <= mul_start_nx;
      wb_valid       <= wb_valid_nx;
      wb_err         <= wb_err_nx;
      wb_data        <= wb_data_nx;
      wb_rd          <= wb_rd_nx;
      mul_rs1        <= mul_rs1_nx;
      mul_rs2        <= mul_rs2_nx;
      mul_rs1_signed <= mul_rs1_signed_nx;
      mul_rs2_signed <= mul_rs2_signed_nx;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = illegal ? ST_RESP : ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (flush) begin
          state_nx = ST_IDLE;
        end else if (!mul_busy) begin
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A flush, either earlier (drop) or on the finishing cycle itself,
        // means the op finishes silently.
        if (wait_end) begin
          state_nx = (drop || flush) ? ST_IDLE : ST_RESP;
        end
      end
      ST_RESP: begin
        if (wb_ready || flush) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------
  always_comb begin
    req_ready_nx      = (state_nx == ST_IDLE);
    wb_valid_nx       = (state_nx == ST_RESP);
    mul_start_nx      = 1'b0;
    wb_err_nx         = wb_err;
    wb_data_nx        = wb_data;
    wb_rd_nx          = wb_rd;
    mul_rs1_nx        = mul_rs1;
    mul_rs2_nx        = mul_rs2;
    mul_rs1_signed_nx = mul_rs1_signed;
    mul_rs2_signed_nx = mul_rs2_signed;
    hi_sel_nx         = hi_sel;
    wait_cnt_nx       = wait_cnt;
    drop_nx           = drop;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          wb_rd_nx = req_rd;
          if (illegal) begin
            wb_err_nx  = 1'b1;
            wb_data_nx = 32'd0;
          end else begin
            // Operands stay in these registers until the next accepted
            // request, which covers the multiplier's re-read at completion.
            mul_rs1_nx        = req_rs1;
            mul_rs2_nx        = req_rs2;
            mul_rs1_signed_nx = (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
            mul_rs2_signed_nx = (req_funct3 == 3'b001);
            hi_sel_nx         = (req_funct3[1:0] != 2'b00);
          end
        end
      end
      ST_LAUNCH: begin
        if (launch_go) begin
          mul_start_nx = 1'b1;
          wait_cnt_nx  = WAIT_LOAD;
          drop_nx      = 1'b0;
        end
      end
      ST_WAIT: begin
        if (wait_end) begin
          drop_nx = 1'b0;
          if (mul_valid) begin
            wb_err_nx  = 1'b0;
            wb_data_nx = hi_sel ? mul_result[63:32] : mul_result[31:0];
          end else begin
            wb_err_nx  = 1'b1;
            wb_data_nx = 32'd0;
          end
        end else begin
          wait_cnt_nx = wait_cnt - 8'd1;
          if (flush) begin
            drop_nx = 1'b1;
          end
        end
      end
      ST_RESP: begin
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
module tb_mul_issue_ctrl;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd;
  logic        flush;
  logic [31:0] mul_rs1;
  logic [31:0] mul_rs2;
  logic        mul_rs1_signed;
  logic        mul_rs2_signed;
  logic        mul_start;
  logic [63:0] mul_result;
  logic        mul_valid;
  logic        mul_busy;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_err;

  int n_tests = 0;
  int n_fail  = 0;
  int wb_cnt  = 0;
  int st_cnt  = 0;

  mul_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .flush(flush),
    .mul_rs1(mul_rs1), .mul_rs2(mul_rs2),
    .mul_rs1_signed(mul_rs1_signed), .mul_rs2_signed(mul_rs2_signed),
    .mul_start(mul_start), .mul_result(mul_result), .mul_valid(mul_valid),
    .mul_busy(mul_busy), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wb_valid === 1'b1) wb_cnt++;
    if (mul_start === 1'b1) st_cnt++;
  end

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          busy;
    int          lat;
    int          stall;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: extend each operand per its signedness, multiply at 64 bits.
  function automatic logic [63:0] ref_prod(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = (f3 == 3'b001 || f3 == 3'b010) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (f3 == 3'b001) ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  function automatic logic [31:0] ref_data(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = ref_prod(f3, a, b);
    if (f3[2]) return 32'd0;
    return (f3 == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin tick; n++; end
    check({name, " req_ready"}, req_ready, 1);
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (mul_start !== 1'b1 && n < 10) begin tick; n++; end
    check({name, " mul_start"}, mul_start, 1);
  endtask

  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_rd = rd;
    tick;
    req_valid = 1'b0; req_funct3 = 3'($urandom); req_rs1 = $urandom; req_rs2 = $urandom; req_rd = 5'($urandom);
  endtask

  // Full op: request, multiplier emulation, writeback with optional stall.
  // lat < 0 means the multiplier never answers.
  task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int busy_cyc, input int lat, input int stall,
                       input logic [31:0] exp_data, input logic exp_err);
    int starts = 0;
    int vcnt = -1;
    int busy_left;
    int wb_c = -1;
    int start_c = -1;
    logic stab_bad = 1'b0;
    logic hold_bad = 1'b0;
    logic [31:0] d0;
    logic [4:0] r0;
    logic e0;
    wait_ready(name);
    send(f3, a, b, rd);
    busy_left = busy_cyc;
    for (int c = 0; c < TIMEOUT + 40; c++) begin
      if (mul_start === 1'b1) begin
        starts++;
        if (start_c < 0) start_c = c;
        vcnt = lat;
      end
      if (start_c >= 0) begin
        if (mul_rs1 !== a || mul_rs2 !== b ||
            mul_rs1_signed !== ((f3 == 3'b001) || (f3 == 3'b010)) ||
            mul_rs2_signed !== (f3 == 3'b001)) stab_bad = 1'b1;
      end
      if (wb_valid === 1'b1) begin wb_c = c; break; end
      mul_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      mul_valid = (vcnt == 0);
      if (vcnt >= 0) vcnt--;
      mul_result = mul_valid ? ref_prod(f3, a, b) : {$urandom, $urandom};
      tick;
    end
    mul_valid = 1'b0; mul_busy = 1'b0;
    check({name, " wb_valid seen"}, (wb_c >= 0), 1);
    check({name, " start pulses"}, starts, f3[2] ? 0 : 1);
    check({name, " wb_data"}, wb_data, exp_data);
    check({name, " wb_err"}, wb_err, exp_err);
    check({name, " wb_rd"}, wb_rd, rd);
    if (!f3[2]) check({name, " operand hold"}, stab_bad, 0);
    if (f3[2])        check({name, " latency"}, wb_c, 0);
    else if (lat < 0) check({name, " timeout latency"}, wb_c - start_c, TIMEOUT);
    else              check({name, " latency"}, wb_c - start_c, lat + 1);
    if (wb_c >= 0) begin
      d0 = wb_data; r0 = wb_rd; e0 = wb_err;
      for (int s = 0; s < stall; s++) begin
        wb_ready = 1'b0;
        mul_valid = (s == 0);
        mul_result = {$urandom, $urandom};
        tick;
        mul_valid = 1'b0;
        if (wb_valid !== 1'b1 || wb_data !== d0 || wb_rd !== r0 || wb_err !== e0 || req_ready !== 1'b0)
          hold_bad = 1'b1;
      end
      if (stall > 0) check({name, " resp hold"}, hold_bad, 0);
      wb_ready = 1'b1;
      tick;
      wb_ready = 1'b0;
      check({name, " wb_valid drop"}, wb_valid, 0);
      check({name, " req_ready back"}, req_ready, 1);
    end
  endtask

  initial begin
    int w0;
    int s0;
    logic [2:0] f3;
    logic [31:0] a;
    logic [31:0] b;
    int r;

    vecs[0]  = '{3'b000, 32'h7,        32'hFFFFFFFD, 5'd5,  0,  2, 0,  32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  2,  1, 10, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{3'b010, 32'hFFFFFFFF, 32'h2,        5'd17, 0,  3, 0,  32'hFFFFFFFF, 1'b0};
    vecs[3]  = '{3'b100, 32'd123,      32'd456,      5'd3,  0,  0, 0,  32'h0,        1'b1};
    vecs[4]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 0,  0, 1,  32'h0,        1'b0};
    vecs[5]  = '{3'b000, 32'h10000,    32'h10000,    5'd1,  1,  4, 0,  32'h0,        1'b0};
    vecs[6]  = '{3'b001, 32'h80000000, 32'h80000000, 5'd7,  0,  2, 0,  32'h40000000, 1'b0};
    vecs[7]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 5'd20, 0,  1, 2,  32'h80000000, 1'b0};
    vecs[8]  = '{3'b011, 32'h80000000, 32'h2,        5'd11, 0,  5, 0,  32'h1,        1'b0};
    vecs[9]  = '{3'b111, 32'h5,        32'h6,        5'd14, 0,  0, 10, 32'h0,        1'b1};
    vecs[10] = '{3'b000, 32'h3,        32'h4,        5'd12, 0, -1, 0,  32'h0,        1'b1};

    rst = 1'b0; req_valid = 1'b0; req_funct3 = 3'b0; req_rs1 = 32'd0; req_rs2 = 32'd0; req_rd = 5'd0;
    flush = 1'b0; mul_result = 64'd0; mul_valid = 1'b0; mul_busy = 1'b0; wb_ready = 1'b0;

    // Reset values and release
    tick; tick;
    check("reset outputs zero", |{req_ready, mul_start, wb_valid, wb_err, wb_data, wb_rd,
                                  mul_rs1, mul_rs2, mul_rs1_signed, mul_rs2_signed}, 0);
    @(negedge clk); rst = 1'b1;
    #1 check("req_ready before first clock", req_ready, 0);
    tick;
    check("req_ready after first clock", req_ready, 1);

    // mul_valid while idle is ignored
    w0 = wb_cnt;
    mul_valid = 1'b1; mul_result = 64'hDEAD; tick; mul_valid = 1'b0; tick;
    check("idle mul_valid ignored", wb_cnt - w0, 0);

    // Directed vector table
    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd,
            vecs[i].busy, vecs[i].lat, vecs[i].stall, vecs[i].exp_data, vecs[i].exp_err);

    // Flush in WAIT: result arrives later but is dropped
    wait_ready("fwait");
    w0 = wb_cnt;
    send(3'b001, 32'd5, 32'd6, 5'd2);
    wait_start("fwait");
    flush = 1'b1; tick; flush = 1'b0;
    tick; tick;
    mul_valid = 1'b1; mul_result = ref_prod(3'b001, 32'd5, 32'd6); tick; mul_valid = 1'b0;
    tick; tick; tick;
    check("fwait no wb_valid", wb_cnt - w0, 0);
    check("fwait req_ready", req_ready, 1);
    do_op("fwait followup", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 0, 2, 0, 32'h0, 1'b0);

    // Flush in LAUNCH while the multiplier is busy
    wait_ready("flaunch");
    w0 = wb_cnt; s0 = st_cnt;
    mul_busy = 1'b1;
    send(3'b000, 32'd9, 32'd9, 5'd6);
    tick;
    flush = 1'b1; tick; flush = 1'b0; mul_busy = 1'b0;
    repeat (5) tick;
    check("flaunch no start", st_cnt - s0, 0);
    check("flaunch no wb_valid", wb_cnt - w0, 0);
    check("flaunch req_ready", req_ready, 1);

    // Flush coincident with a handshake
    wait_ready("fhs");
    w0 = wb_cnt; s0 = st_cnt;
    flush = 1'b1; send(3'b011, 32'd1, 32'd2, 5'd8); flush = 1'b0;
    repeat (5) tick;
    check("fhs no start", st_cnt - s0, 0);
    check("fhs no wb_valid", wb_cnt - w0, 0);
    check("fhs req_ready", req_ready, 1);

    // Flush in RESP
    wait_ready("fresp");
    send(3'b000, 32'd3, 32'd4, 5'd10);
    wait_start("fresp");
    mul_valid = 1'b1; mul_result = 64'd12; tick; mul_valid = 1'b0;
    check("fresp wb_valid", wb_valid, 1);
    check("fresp wb_data", wb_data, 32'd12);
    flush = 1'b1; tick; flush = 1'b0;
    check("fresp wb_valid dropped", wb_valid, 0);
    check("fresp req_ready", req_ready, 1);

    // Flush coincident with mul_valid
    wait_ready("fvalid");
    w0 = wb_cnt;
    send(3'b011, 32'd3, 32'd4, 5'd13);
    wait_start("fvalid");
    tick;
    flush = 1'b1; mul_valid = 1'b1; mul_result = 64'h1_0000_0000; tick;
    flush = 1'b0; mul_valid = 1'b0;
    repeat (3) tick;
    check("fvalid no wb_valid", wb_cnt - w0, 0);
    check("fvalid req_ready", req_ready, 1);

    // Reset mid-WAIT
    wait_ready("rstwait");
    w0 = wb_cnt;
    send(3'b011, 32'hFFFFFFFF, 32'h3, 5'd19);
    wait_start("rstwait");
    tick;
    #2 rst = 1'b0;
    #1 check("rstwait outputs zero", |{req_ready, mul_start, wb_valid, wb_err, wb_data, wb_rd,
                                       mul_rs1, mul_rs2, mul_rs1_signed, mul_rs2_signed}, 0);
    @(negedge clk); rst = 1'b1;
    tick;
    check("rstwait req_ready", req_ready, 1);
    repeat (3) tick;
    check("rstwait no wb_valid", wb_cnt - w0, 0);

    // Randomized ops against the reference model
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      f3 = (r < 8) ? 3'(r) : 3'(r - 8);
      a = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      do_op($sformatf("rnd%0d", i), f3, a, b, 5'($urandom), $urandom_range(0, 2),
            $urandom_range(0, 5), $urandom_range(0, 3), ref_data(f3, a, b), f3[2]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
